// File: rtl/gpio_input_controller.sv
// GPIO input controller: per-channel sync, debounce and edge capture with a level irq.
// Define GPIO_IC_TIMESTAMP_EN to add a free-running counter latched into TSTAMP on capture.

module gpio_ic_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       db_en,
  input  logic [1:0] sel,
  input  logic       pin,
  output logic       level,
  output logic       hit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1, sync2, level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Disabled channels (or global disable) follow the synchronizer with no filtering.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (!enable || !db_en) begin
      level_d = sync2;
    end else if (sync2 != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2;
      else                                   cnt_d   = cnt_q + CW'(1);
    end
    hit = enable && ((sel[0] && level_d && !level_q) ||
                     (sel[1] && !level_d && level_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1   <= pin;
      sync2   <= sync1;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
endmodule

module gpio_input_controller #(
  parameter int NUM_INPUTS      = 12,
  parameter int DATA_WIDTH      = 64,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [2:0]            register_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_INPUTS-1:0] in_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  irq
);
  // Widened copy of the write bus so narrow DATA_WIDTH builds can still slice every field.
  localparam int XW = DATA_WIDTH + 2 * NUM_INPUTS + 1;

  logic [XW-1:0]                 wx;
  logic                          unused_wx;
  logic [NUM_INPUTS:0]           ctrl_q;
  logic [NUM_INPUTS-1:0]         mask_q, cap_q, cap_d, clr, level, hit;
  logic [NUM_INPUTS-1:0][1:0]    sel_q;
  logic [DATA_WIDTH-1:0]         tstamp;
  logic                          done_q, irq_q;
  logic                          wr_ctrl, wr_cap, wr_mask, wr_sel;

  assign wx        = XW'(wr_data);
  assign unused_wx = ^wx;
  assign wr_ctrl   = we && (register_addr == 3'd0);
  assign wr_cap    = we && (register_addr == 3'd2);
  assign wr_mask   = we && (register_addr == 3'd3);
  assign wr_sel    = we && (register_addr == 3'd4);

  gpio_ic_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_INPUTS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .enable(ctrl_q[0]),
    .db_en (ctrl_q[NUM_INPUTS:1]),
    .sel   (sel_q),
    .pin   (in_data),
    .level (level),
    .hit   (hit)
  );

  // New edges are OR'd in after the clear, so a coincident set survives.
  always_comb begin
    clr   = wr_cap ? wx[NUM_INPUTS-1:0] : '0;
    cap_d = ctrl_q[0] ? ((cap_q & ~clr) | hit) : cap_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      mask_q <= '0;
      sel_q  <= '0;
      cap_q  <= '0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wx[NUM_INPUTS:0];
      if (wr_mask) mask_q <= wx[NUM_INPUTS-1:0];
      if (wr_sel)  sel_q  <= wx[2*NUM_INPUTS-1:0];
      cap_q  <= cap_d;
      done_q <= we;
      irq_q  <= |(cap_q & mask_q);
    end
  end

`ifdef GPIO_IC_TIMESTAMP_EN
  logic [DATA_WIDTH-1:0] ts_cnt, ts_q;
  logic                  new_set;

  assign new_set = |(cap_d & ~cap_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + DATA_WIDTH'(1);
      if (new_set) ts_q <= ts_cnt;
    end
  end

  assign tstamp = ts_q;
`else
  assign tstamp = '0;
`endif

  always_comb begin
    rd_data = '0;
    case (register_addr)
      3'd0:    rd_data = DATA_WIDTH'(ctrl_q);
      3'd1:    rd_data = DATA_WIDTH'(level);
      3'd2:    rd_data = DATA_WIDTH'(cap_q);
      3'd3:    rd_data = DATA_WIDTH'(mask_q);
      3'd4:    rd_data = DATA_WIDTH'(sel_q);
      3'd5:    rd_data = tstamp;
      default: rd_data = '0;
    endcase
  end

  assign done = done_q;
  assign irq  = irq_q;
endmodule

// File: tb/tb_gpio_input_controller.sv
// Self-checking bench for gpio_input_controller: register table, latency, debounce,
// clear/set race, global disable, reset-vs-write and TSTAMP behaviour.
module tb_gpio_input_controller;
  localparam int N  = 12;
  localparam int DW = 64;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst, we;
  logic [2:0]    register_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [N-1:0]  in_data;
  logic          done, irq;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  logic [63:0] expq[$];

  typedef struct {
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[9];

  gpio_input_controller #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .we(we), .register_addr(register_addr), .wr_data(wr_data),
    .in_data(in_data), .rd_data(rd_data), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [63:0] exp);
    expq.push_back(exp);
    register_addr = a;
    #1;
    chk(nm, rd_data, expq.pop_front());
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    we = 1'b1;
    register_addr = a;
    wr_data = d;
    tick();
    we = 1'b0;
    chk("done_after_write", 64'(done), 64'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF};
    vecs[1] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF};
    vecs[2] = '{3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFF_FFFF};
    vecs[3] = '{3'd1, 64'h0000_0000_0000_ABCD, 64'h0};
    vecs[4] = '{3'd5, 64'h0000_0000_0000_1234, 64'h0};
    vecs[5] = '{3'd6, 64'h0000_0000_0000_0055, 64'h0};
    vecs[6] = '{3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[7] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[8] = '{3'd0, 64'h0, 64'h0};

    rst = 1'b1; we = 1'b0; register_addr = '0; wr_data = '0; in_data = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0; cyc = 0;

    chk("rst_done", 64'(done), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    rd("rst_ctrl", 3'd0, 64'h0);
    rd("rst_data", 3'd1, 64'h0);
    rd("rst_cap", 3'd2, 64'h0);
    rd("rst_mask", 3'd3, 64'h0);
    rd("rst_sel", 3'd4, 64'h0);
    rd("rst_tstamp", 3'd5, 64'h0);

    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd("reg_table", vecs[i].addr, vecs[i].exp);
    end
    pulse_rst();

    // back-to-back writes give back-to-back done pulses
    we = 1'b1; register_addr = 3'd0; wr_data = 64'h1;
    tick();
    chk("b2b_done1", 64'(done), 64'd1);
    register_addr = 3'd3; wr_data = 64'h1;
    tick();
    chk("b2b_done2", 64'(done), 64'd1);
    we = 1'b0;
    tick();
    chk("b2b_done_end", 64'(done), 64'd0);
    wr(3'd4, 64'h1);
    rd("cfg_ctrl", 3'd0, 64'h1);
    rd("cfg_mask", 3'd3, 64'h1);

    // rising edge latency with debounce off: cap at +3, irq at +4
    in_data[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      expq.push_back((k >= 3) ? 64'h1 : 64'h0);
      expq.push_back((k >= 4) ? 64'h1 : 64'h0);
    end
    register_addr = 3'd2;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("lat_cap", rd_data, expq.pop_front());
      chk("lat_irq", 64'(irq), expq.pop_front());
    end
    rd("lat_data", 3'd1, 64'h1);
    in_data[0] = 1'b0;
    wait_n(4);
    rd("fall_unselected", 3'd2, 64'h1);
    wr(3'd2, 64'h1);
    rd("clear_cap", 3'd2, 64'h0);
    tick();
    chk("irq_drop", 64'(irq), 64'd0);

    // partial clear, then clear racing a new edge
    wr(3'd4, 64'h11);
    in_data[0] = 1'b1; in_data[2] = 1'b1;
    wait_n(4);
    rd("cap_05", 3'd2, 64'h5);
    wr(3'd2, 64'h4);
    rd("partial_clear", 3'd2, 64'h1);
    tick();
    chk("single_done", 64'(done), 64'd0);
    in_data[2] = 1'b0;
    wait_n(4);
    rd("ch2_fall_unsel", 3'd2, 64'h1);
    wr(3'd4, 64'h31);
    in_data[2] = 1'b1;
    wait_n(3);
    rd("ch2_both_rise", 3'd2, 64'h5);
    in_data[2] = 1'b0;
    tick(); tick();
    we = 1'b1; register_addr = 3'd2; wr_data = 64'h4;
    tick();
    we = 1'b0;
    rd("set_wins", 3'd2, 64'h5);
    wait_n(2);
    rd("set_wins_hold", 3'd2, 64'h5);

    // both-edge select on channel 3, then global disable
    wr(3'd2, 64'hFFF);
    wr(3'd4, 64'hF1);
    in_data[3] = 1'b1;
    wait_n(4);
    wr(3'd2, 64'h8);
    rd("ch3_cleared", 3'd2, 64'h0);
    in_data[3] = 1'b0;
    wait_n(4);
    rd("ch3_fall", 3'd2, 64'h8);
    wr(3'd2, 64'h8);
    wr(3'd0, 64'h0);
    in_data[3] = 1'b1;
    wait_n(4);
    rd("dis_track", 3'd1, 64'h9);
    in_data[3] = 1'b0;
    wait_n(4);
    rd("dis_frozen", 3'd2, 64'h0);
    rd("dis_track2", 3'd1, 64'h1);

    // debounce: short pulse rejected, long pulse accepted on the DB-th sample
    in_data = '0;
    pulse_rst();
    wr(3'd0, 64'h3);
    wr(3'd4, 64'h1);
    wr(3'd3, 64'h1);
    wait_n(4);
    in_data[0] = 1'b1;
    wait_n(10);
    in_data[0] = 1'b0;
    wait_n(25);
    rd("db_short", 3'd2, 64'h0);
    in_data[0] = 1'b1;
    for (int k = 1; k <= DB + 2; k++) expq.push_back((k == DB + 2) ? 64'h1 : 64'h0);
    register_addr = 3'd2;
    for (int k = 1; k <= DB + 2; k++) begin
      tick();
      chk("db_long", rd_data, expq.pop_front());
    end
    tick();
    chk("db_irq", 64'(irq), 64'd1);

    // reset during a write discards it
    in_data = '0;
    rst = 1'b1; we = 1'b1; register_addr = 3'd0; wr_data = 64'hFFFF;
    tick();
    rst = 1'b0; we = 1'b0; cyc = 0;
    chk("rstwr_done", 64'(done), 64'd0);
    chk("rstwr_irq", 64'(irq), 64'd0);
    rd("rstwr_ctrl", 3'd0, 64'h0);
    rd("rstwr_cap", 3'd2, 64'h0);
    rd("rstwr_data", 3'd1, 64'h0);
    tick();
    chk("rstwr_no_done", 64'(done), 64'd0);

    // timestamp on capture
    wr(3'd0, 64'h1);
    wr(3'd3, 64'h1);
    wr(3'd4, 64'h1);
    in_data[0] = 1'b1;
    wait_n(3);
    rd("ts_cap", 3'd2, 64'h1);
`ifdef GPIO_IC_TIMESTAMP_EN
    rd("tstamp", 3'd5, 64'(cyc - 1));
`else
    rd("tstamp", 3'd5, 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
